// File: rtl/kc705_c2h_pattern_tx.sv
// C2H test-pattern transmitter: framed 64-bit {seq, k} packets on an AXI4-Stream master.
// Optional header beat per packet when the C2H_HEADER_EN macro is defined.
module kc705_c2h_pattern_tx #(
    parameter int GAP_CYCLES = 4,
    parameter int HB_DIV_W   = 26
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        enable,
    input  logic [15:0] pkt_len,
    input  logic [31:0] pkt_limit,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic        done,
    output logic [31:0] pkts_sent,
    output logic        led_hb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_t        state_r, state_s;
    logic [31:0]   seq_r, seq_s;
    logic [31:0]   pkts_r, pkts_s;
    logic [15:0]   word_r, word_s;
    logic [15:0]   len_r, len_s;
    logic [15:0]   gap_r, gap_s;
    logic [63:0]   tdata_r;
    logic [7:0]    tkeep_r;
    logic          tvalid_r, tlast_r, busy_r, done_r, led_r;
    logic [HB_DIV_W-1:0] hb_div_r;
    logic          accept_s;
    logic [15:0]   len_sample_s;
    logic [31:0]   pkts_inc_s;

    // Index of the final beat (header counts as index 0 when present).
    function automatic logic [15:0] last_idx(input logic [15:0] len);
`ifdef C2H_HEADER_EN
        return len;
`else
        return len - 16'd1;
`endif
    endfunction

    function automatic logic [63:0] beat_data(input logic [31:0] seq,
                                              input logic [15:0] idx,
                                              input logic [15:0] len);
        logic [63:0] beat;
`ifdef C2H_HEADER_EN
        if (idx == 16'd0) begin
            beat = {16'hCE9C, len, seq};
        end else begin
            beat = {seq, 16'h0000, idx - 16'd1};
        end
`else
        beat = {seq, 16'h0000, idx};
        if (len == 16'd0) begin
            beat = 64'h0000_0000_0000_0000;
        end else begin
            beat = {seq, 16'h0000, idx};
        end
`endif
        return beat;
    endfunction

    assign accept_s     = tvalid_r & m_axis_tready;
    assign len_sample_s = (pkt_len == 16'd0) ? 16'd1 : pkt_len;
    assign pkts_inc_s   = pkts_r + 32'd1;

    // Next-state and next-counter logic.
    always_comb begin
        state_s = state_r;
        seq_s   = seq_r;
        pkts_s  = pkts_r;
        word_s  = word_r;
        len_s   = len_r;
        gap_s   = gap_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_s = SEND;
                    seq_s   = 32'd0;
                    pkts_s  = 32'd0;
                    word_s  = 16'd0;
                    len_s   = len_sample_s;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (accept_s && tlast_r) begin
                    pkts_s = pkts_inc_s;
                    seq_s  = seq_r + 32'd1;
                    word_s = 16'd0;
                    // Limit check wins over enable so a finished session always reports done.
                    if ((pkt_limit != 32'd0) && (pkts_inc_s == pkt_limit)) begin
                        state_s = DONE;
                    end else if (!enable) begin
                        state_s = IDLE;
                    end else if (GAP_CYCLES > 0) begin
                        state_s = GAP;
                        gap_s   = 16'd0;
                    end else begin
                        state_s = SEND;
                        len_s   = len_sample_s;
                    end
                end else if (accept_s) begin
                    word_s = word_r + 16'd1;
                end else begin
                    state_s = SEND;
                end
            end
            GAP: begin
                if (gap_r == GAP_LAST) begin
                    if (enable) begin
                        state_s = SEND;
                        word_s  = 16'd0;
                        len_s   = len_sample_s;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    gap_s = gap_r + 16'd1;
                end
            end
            DONE: begin
                if (!enable) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered stream/status outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r  <= IDLE;
            seq_r    <= 32'd0;
            pkts_r   <= 32'd0;
            word_r   <= 16'd0;
            len_r    <= 16'd0;
            gap_r    <= 16'd0;
            tdata_r  <= 64'd0;
            tkeep_r  <= 8'h00;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            seq_r    <= seq_s;
            pkts_r   <= pkts_s;
            word_r   <= word_s;
            len_r    <= len_s;
            gap_r    <= gap_s;
            busy_r   <= (state_s == SEND) || (state_s == GAP);
            done_r   <= (state_s == DONE);
            if (state_s == SEND) begin
                tdata_r  <= beat_data(seq_s, word_s, len_s);
                tkeep_r  <= 8'hFF;
                tvalid_r <= 1'b1;
                tlast_r  <= (word_s == last_idx(len_s));
            end else begin
                tdata_r  <= 64'd0;
                tkeep_r  <= 8'h00;
                tvalid_r <= 1'b0;
                tlast_r  <= 1'b0;
            end
        end
    end

    // Heartbeat divider runs only while busy.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hb_div_r <= '0;
            led_r    <= 1'b0;
        end else if (busy_r) begin
            hb_div_r <= hb_div_r + {{(HB_DIV_W-1){1'b0}}, 1'b1};
            if (&hb_div_r) begin
                led_r <= ~led_r;
            end else begin
                led_r <= led_r;
            end
        end else begin
            hb_div_r <= hb_div_r;
            led_r    <= led_r;
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tkeep  = tkeep_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pkts_sent     = pkts_r;
    assign led_hb        = led_r;

endmodule
